prog_mem: RTL and testbench

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem.sv | 145 ++++++++++++++
 tb/tb_prog_mem.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
// Program memory with a byte-serial loader: 2^(PC_WIDTH-1) 16-bit words, byte-addressed fetch.
// Latency: fetch read is registered, out_instr valid one cycle after in_pc is sampled.
// Backpressure: out_load_ready is high only during a load session; fetch returns nop while busy.
module prog_mem #(
  parameter int PC_WIDTH   = 12,
  parameter int PMEM_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic [PMEM_WIDTH-1:0] out_instr,
  input  logic                  in_load_start,
  input  logic [PC_WIDTH-1:0]   in_load_addr,
  input  logic                  in_load_valid,
  input  logic [7:0]            in_load_byte,
  input  logic                  in_load_last,
  output logic                  out_load_ready,
  output logic                  out_busy,
  output logic                  out_load_overflow
);

  // Word address width: the program counter is a byte address, bit 0 selects nothing.
  localparam int AW    = PC_WIDTH - 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t               state;
  logic [AW-1:0]        wa;
  logic [7:0]           lo_byte;
  logic [PMEM_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  mem_we;
  logic [7:0]            wr_hi;
  logic [7:0]            wr_lo;
  logic [PMEM_WIDTH-1:0] mem_wdat;
  logic [AW-1:0]         fetch_idx;

  // Byte-lane select bits of both addresses are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_pc[0], in_load_addr[0]};

  assign fetch_idx = in_pc[PC_WIDTH-1:1];

  // Busy and ready are pure decodes of the registered state, so they are glitch-free
  // and fall to zero the instant reset forces the state to IDLE.
  assign out_busy       = (state != IDLE);
  assign out_load_ready = out_busy;

  // A byte is taken only when both sides agree in the same cycle.
  assign accept = in_load_valid & out_load_ready;

  // Memory is written on every accepted high byte, and on a low byte that ends the
  // session (odd-length load, upper byte padded with zero).
  // Compute write enable and assembled write word for the current cycle.
  always_comb begin
    mem_we = 1'b0;
    wr_hi  = 8'h00;
    wr_lo  = 8'h00;
    if (accept) begin
      if (state == HI) begin
        mem_we = 1'b1;
        wr_hi  = in_load_byte;
        wr_lo  = lo_byte;
      end else if (state == LO && in_load_last) begin
        mem_we = 1'b1;
        wr_hi  = 8'h00;
        wr_lo  = in_load_byte;
      end
    end
  end

  assign mem_wdat = PMEM_WIDTH'({wr_hi, wr_lo});

  // Loader FSM: tracks byte phase, word address, pending low byte and the wrap flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      wa                <= '0;
      lo_byte           <= 8'h00;
      out_load_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_load_start) begin
            wa                <= in_load_addr[PC_WIDTH-1:1];
            out_load_overflow <= 1'b0;
            state             <= LO;
          end
        end
        LO: begin
          if (accept) begin
            if (in_load_last) begin
              wa    <= wa + 1'b1;
              state <= IDLE;
              if (&wa) begin
                out_load_overflow <= 1'b1;
              end
            end else begin
              lo_byte <= in_load_byte;
              state   <= HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            wa <= wa + 1'b1;
            if (&wa) begin
              out_load_overflow <= 1'b1;
            end
            state <= in_load_last ? IDLE : LO;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage array: no reset so contents survive a reset mid-session.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wa] <= mem_wdat;
    end
  end

  // Registered fetch port: nop while a session owns the memory, otherwise a plain read.
  // A word written on the edge that ends a session is visible to the very next read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_instr <= '0;
    end else if (out_busy) begin
      out_instr <= '0;
    end else begin
      out_instr <= mem[fetch_idx];
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: loader sessions, fetch port, wrap flag and reset behaviour.
// Latency: expects one-cycle registered fetch and nop while busy.
// Backpressure: loader bytes are presented with and without valid gaps.
module tb_prog_mem;

  logic        clock;
  logic        reset;
  logic [11:0] in_pc;
  logic [15:0] out_instr;
  logic        in_load_start;
  logic [11:0] in_load_addr;
  logic        in_load_valid;
  logic [7:0]  in_load_byte;
  logic        in_load_last;
  logic        out_load_ready;
  logic        out_busy;
  logic        out_load_overflow;

  int checks   = 0;
  int failures = 0;

  prog_mem #(
    .PC_WIDTH  (12),
    .PMEM_WIDTH(16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_pc            (in_pc),
    .out_instr        (out_instr),
    .in_load_start    (in_load_start),
    .in_load_addr     (in_load_addr),
    .in_load_valid    (in_load_valid),
    .in_load_byte     (in_load_byte),
    .in_load_last     (in_load_last),
    .out_load_ready   (out_load_ready),
    .out_busy         (out_busy),
    .out_load_overflow(out_load_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_start(input logic [11:0] addr);
    in_load_start = 1'b1;
    in_load_addr  = addr;
    tick();
    in_load_start = 1'b0;
    in_load_addr  = 12'h000;
  endtask

  task automatic load_byte(input logic [7:0] b, input logic last);
    in_load_valid = 1'b1;
    in_load_byte  = b;
    in_load_last  = last;
    tick();
    in_load_valid = 1'b0;
    in_load_byte  = 8'h00;
    in_load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [11:0] pc, output logic [15:0] v);
    in_pc = pc;
    tick();
    v = out_instr;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (out_instr !== 16'h0000) begin
      failures++; $display("FAIL reset_instr: got %h expected 0000", out_instr);
    end
    checks++;
    if ({out_busy, out_load_ready, out_load_overflow} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {out_busy, out_load_ready, out_load_overflow});
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    logic [15:0] v;
    load_start(12'h000);
    checks++;
    if ({out_busy, out_load_ready} !== 2'b11) begin
      failures++; $display("FAIL basic_busy: got %b expected 11", {out_busy, out_load_ready});
    end
    load_byte(8'h34, 1'b0);
    load_byte(8'h12, 1'b0);
    load_byte(8'hCD, 1'b0);
    load_byte(8'hAB, 1'b1);
    checks++;
    if ({out_busy, out_load_ready} !== 2'b00) begin
      failures++; $display("FAIL basic_idle: got %b expected 00", {out_busy, out_load_ready});
    end
    checks++;
    if (out_instr !== 16'h0000) begin
      failures++; $display("FAIL basic_nop_last: got %h expected 0000", out_instr);
    end
    fetch(12'h002, v);
    checks++;
    if (v !== 16'hABCD) begin
      failures++; $display("FAIL basic_word1: got %h expected abcd", v);
    end
    fetch(12'h000, v);
    checks++;
    if (v !== 16'h1234) begin
      failures++; $display("FAIL basic_word0: got %h expected 1234", v);
    end
    fetch(12'h003, v);
    checks++;
    if (v !== 16'hABCD) begin
      failures++; $display("FAIL basic_pc0_ignored: got %h expected abcd", v);
    end
  endtask

  task automatic test_odd_length();
    logic [15:0] v;
    load_start(12'h010);
    load_byte(8'h77, 1'b1);
    checks++;
    if (out_busy !== 1'b0) begin
      failures++; $display("FAIL odd_busy: got %b expected 0", out_busy);
    end
    fetch(12'h010, v);
    checks++;
    if (v !== 16'h0077) begin
      failures++; $display("FAIL odd_word8: got %h expected 0077", v);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    load_start(12'hFFE);
    load_byte(8'h01, 1'b0);
    checks++;
    if (out_load_overflow !== 1'b0) begin
      failures++; $display("FAIL wrap_early: got %b expected 0", out_load_overflow);
    end
    load_byte(8'h02, 1'b0);
    checks++;
    if (out_load_overflow !== 1'b1) begin
      failures++; $display("FAIL wrap_set: got %b expected 1", out_load_overflow);
    end
    load_byte(8'h03, 1'b0);
    load_byte(8'h04, 1'b1);
    checks++;
    if (out_load_overflow !== 1'b1) begin
      failures++; $display("FAIL wrap_sticky: got %b expected 1", out_load_overflow);
    end
    fetch(12'hFFE, v);
    checks++;
    if (v !== 16'h0201) begin
      failures++; $display("FAIL wrap_top: got %h expected 0201", v);
    end
    fetch(12'h000, v);
    checks++;
    if (v !== 16'h0403) begin
      failures++; $display("FAIL wrap_bottom: got %h expected 0403", v);
    end
    load_start(12'h100);
    checks++;
    if (out_load_overflow !== 1'b0) begin
      failures++; $display("FAIL wrap_clear: got %b expected 0", out_load_overflow);
    end
    load_byte(8'h55, 1'b0);
    load_byte(8'hAA, 1'b1);
    fetch(12'h100, v);
    checks++;
    if (v !== 16'hAA55) begin
      failures++; $display("FAIL wrap_next_session: got %h expected aa55", v);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] v;
    logic [7:0]  seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    // Known background in words 0x10..0x12, then a gapless reference copy at 0x040.
    load_start(12'h020);
    load_byte(8'hA1, 1'b0); load_byte(8'hA2, 1'b0);
    load_byte(8'hA3, 1'b0); load_byte(8'hA4, 1'b0);
    load_byte(8'hA5, 1'b0); load_byte(8'hA6, 1'b1);
    load_start(12'h040);
    for (int i = 0; i < 4; i++) load_byte(seq[i], i == 3);
    // Gapped load over the background.
    load_start(12'h020);
    for (int i = 0; i < 4; i++) begin
      load_byte(seq[i], i == 3);
      if (i != 3) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          checks++;
          if (out_load_ready !== 1'b1 || out_instr !== 16'h0000) begin
            failures++; $display("FAIL bp_gap: ready=%b instr=%h expected ready=1 instr=0000", out_load_ready, out_instr);
          end
        end
      end
    end
    fetch(12'h020, v);
    checks++;
    if (v !== 16'h2211) begin
      failures++; $display("FAIL bp_word0: got %h expected 2211", v);
    end
    fetch(12'h022, v);
    checks++;
    if (v !== 16'h4433) begin
      failures++; $display("FAIL bp_word1: got %h expected 4433", v);
    end
    fetch(12'h024, v);
    checks++;
    if (v !== 16'hA6A5) begin
      failures++; $display("FAIL bp_untouched: got %h expected a6a5", v);
    end
    fetch(12'h040, v);
    checks++;
    if (v !== 16'h2211) begin
      failures++; $display("FAIL bp_ref0: got %h expected 2211", v);
    end
    fetch(12'h042, v);
    checks++;
    if (v !== 16'h4433) begin
      failures++; $display("FAIL bp_ref1: got %h expected 4433", v);
    end
  endtask

  task automatic test_nop_during_session();
    logic [15:0] v;
    load_start(12'h060);
    fetch(12'h020, v);
    checks++;
    if (v !== 16'h0000) begin
      failures++; $display("FAIL nop_fetch: got %h expected 0000", v);
    end
    load_byte(8'h99, 1'b0);
    // Restart attempt while in HI must be ignored.
    load_start(12'h200);
    checks++;
    if (out_busy !== 1'b1) begin
      failures++; $display("FAIL nop_busy_hold: got %b expected 1", out_busy);
    end
    load_byte(8'h88, 1'b1);
    checks++;
    if (out_busy !== 1'b0) begin
      failures++; $display("FAIL nop_session_end: got %b expected 0", out_busy);
    end
    fetch(12'h060, v);
    checks++;
    if (v !== 16'h8899) begin
      failures++; $display("FAIL nop_word: got %h expected 8899", v);
    end
  endtask

  task automatic test_reset_mid_session();
    logic [15:0] v;
    load_start(12'h082);
    load_byte(8'hEF, 1'b0);
    load_byte(8'hBE, 1'b1);
    load_start(12'h080);
    load_byte(8'h10, 1'b0);
    load_byte(8'h20, 1'b0);
    load_byte(8'h30, 1'b0);
    checks++;
    if (out_busy !== 1'b1) begin
      failures++; $display("FAIL rst_pre_busy: got %b expected 1", out_busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_busy, out_load_ready, out_load_overflow} !== 3'b000 || out_instr !== 16'h0000) begin
      failures++; $display("FAIL rst_async: flags=%b instr=%h expected 000 0000", {out_busy, out_load_ready, out_load_overflow}, out_instr);
    end
    tick();
    tick();
    reset = 1'b1;
    fetch(12'h080, v);
    checks++;
    if (v !== 16'h2010) begin
      failures++; $display("FAIL rst_kept: got %h expected 2010", v);
    end
    fetch(12'h082, v);
    checks++;
    if (v !== 16'hBEEF) begin
      failures++; $display("FAIL rst_pending_dropped: got %h expected beef", v);
    end
  endtask

  initial begin
    reset         = 1'b0;
    in_pc         = 12'h000;
    in_load_start = 1'b0;
    in_load_addr  = 12'h000;
    in_load_valid = 1'b0;
    in_load_byte  = 8'h00;
    in_load_last  = 1'b0;
    test_reset();
    test_basic_load();
    test_odd_length();
    test_wrap();
    test_backpressure();
    test_nop_during_session();
    test_reset_mid_session();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
